// File: rtl/binary_adder_subtracter_pkg.sv
// Shared arithmetic constants for the adder/subtracter.
// OP_ADD / OP_SUB are the encodings of the mode bit s.
package binary_adder_subtracter_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/binary_adder_subtracter_if.sv
// Operand/result bundle for the adder/subtracter.
// master drives in_valid/a/b/s; slave returns sum/v/c/out_valid.
interface binary_adder_subtracter_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] sum;
    logic             v;
    logic             c;
    logic             out_valid;

    modport master (
        output in_valid, a, b, s,
        input  sum, v, c, out_valid
    );

    modport slave (
        input  in_valid, a, b, s,
        output sum, v, c, out_valid
    );

endinterface

// File: rtl/binary_adder_subtracter_full_adder.sv
// One-bit full adder cell of the ripple chain.
// Ports: x, y, cin in; s (sum bit), cout (majority) out.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/binary_adder_subtracter.sv
// Registered ripple-carry add/sub with overflow and carry-out.
// Ports: clk, rst_n (async low), bus (slave: operands in, result out).
module binary_adder_subtracter
    import binary_adder_subtracter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    binary_adder_subtracter_if.slave   bus
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   cy;
    logic             v_c;

    // Subtract is a + ~b + 1: invert B and inject the +1 as carry-in.
    assign sub   = (bus.s == OP_SUB);
    assign b_eff = bus.b ^ {WIDTH{sub}};
    assign cy[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        full_adder u_fa (
            .x    (bus.a[i]),
            .y    (b_eff[i]),
            .cin  (cy[i]),
            .s    (sum_c[i]),
            .cout (cy[i+1])
        );
    end

    // Signed overflow: carry into MSB differs from carry out of MSB.
    assign v_c = cy[WIDTH] ^ cy[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum       <= '0;
            bus.v         <= 1'b0;
            bus.c         <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum <= sum_c;
                bus.v   <= v_c;
                bus.c   <= cy[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_binary_adder_subtracter.sv
// Bench for binary_adder_subtracter, WIDTH=4.
// Table vectors, exhaustive sweep and reset corner via a scoreboard.
module tb_binary_adder_subtracter;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         v;
        logic         c;
    } vec_t;

    typedef struct {
        logic         ov;
        logic [W-1:0] sum;
        logic         v;
        logic         c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb[$];
    exp_t last;
    exp_t got;

    binary_adder_subtracter_if #(.WIDTH(W)) bif ();

    binary_adder_subtracter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [W-1:0] a,
                                   logic [W-1:0] b,
                                   logic s);
        exp_t e;
        int   ia;
        int   ib;
        int   r;
        ia = int'($signed(a));
        ib = int'($signed(b));
        r  = s ? ia - ib : ia + ib;
        e.ov  = 1'b1;
        e.sum = r[W-1:0];
        e.v   = (r > 7) || (r < -8);
        if (s)
            e.c = (a >= b);
        else
            e.c = (int'(a) + int'(b)) > 15;
        return e;
    endfunction

    task automatic check(string nm, exp_t e);
        tests++;
        if (bif.out_valid !== e.ov || bif.sum !== e.sum ||
            bif.v !== e.v || bif.c !== e.c) begin
            fails++;
            $display("FAIL %s: got ov=%b sum=%b v=%b c=%b want ov=%b sum=%b v=%b c=%b",
                     nm, bif.out_valid, bif.sum, bif.v, bif.c,
                     e.ov, e.sum, e.v, e.c);
        end
    endtask

    task automatic cycle(logic vld, logic [W-1:0] a,
                         logic [W-1:0] b, logic s,
                         exp_t e);
        exp_t q;
        @(negedge clk);
        bif.in_valid = vld;
        bif.a        = a;
        bif.b        = b;
        bif.s        = s;
        if (vld) begin
            q    = e;
            last = e;
        end else begin
            q    = last;
            q.ov = 1'b0;
        end
        sb.push_back(q);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && sb.size() > 0) begin
            got = sb.pop_front();
            check("sb", got);
        end
    end

    vec_t tbl[6];
    exp_t e;
    exp_t z;

    initial begin
        tests = 0;
        fails = 0;
        z = '{ov: 1'b0, sum: '0, v: 1'b0, c: 1'b0};
        last = z;
        tbl[0] = '{4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[1] = '{4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1};
        tbl[2] = '{4'b0010, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0};
        tbl[3] = '{4'b0100, 4'b0110, 1'b0, 4'b1010, 1'b1, 1'b0};
        tbl[4] = '{4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b1, 1'b1};
        tbl[5] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};

        rst_n        = 1'b0;
        bif.in_valid = 1'b0;
        bif.a        = '0;
        bif.b        = '0;
        bif.s        = 1'b0;
        #1;
        check("reset0", z);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back table vectors
        for (int i = 0; i < 6; i++) begin
            e = '{ov: 1'b1, sum: tbl[i].sum,
                  v: tbl[i].v, c: tbl[i].c};
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, e);
        end
        // idle cycles: out_valid drops, result held
        cycle(1'b0, 4'b1111, 4'b1111, 1'b0, z);
        cycle(1'b0, 4'b0101, 4'b0011, 1'b1, z);

        // exhaustive sweep, interleaved with occasional idles
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    e = model(4'(a), 4'(b), 1'(s));
                    cycle(1'b1, 4'(a), 4'(b), 1'(s), e);
                    if ($urandom_range(0, 15) == 0)
                        cycle(1'b0, 4'($urandom), 4'($urandom),
                              1'($urandom), z);
                end

        // reset mid-stream with a result in flight
        e = model(4'b0111, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0111, 4'b0001, 1'b0, e);
        @(posedge clk);
        #3;
        bif.a = 4'b0101;
        bif.b = 4'b0101;
        rst_n = 1'b0;
        last  = z;
        #1;
        check("rst_async", z);
        @(posedge clk);
        #2;
        check("rst_hold", z);
        @(negedge clk);
        rst_n        = 1'b1;
        bif.in_valid = 1'b0;
        e = '{ov: 1'b1, sum: 4'b0100, v: 1'b0, c: 1'b0};
        cycle(1'b1, 4'b0001, 4'b0011, 1'b0, e);
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, z);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
